// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: linear frequency-sweep sequencer feeding the K (frequency)
// and P (phase offset) inputs of the DDS phase-accumulator core.
// Supports single-shot, repeating sawtooth and triangle sweeps with a
// programmable per-value dwell, abort, and configuration-error reporting.
module dds_sweep_ctrl #(
  parameter int unsigned KW = 32,
  parameter int unsigned PW = 11,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [KW-1:0] k_start,
  input  logic [KW-1:0] k_stop,
  input  logic [KW-1:0] k_step,
  input  logic [DW-1:0] dwell,
  input  logic [PW-1:0] p_cfg,
  output logic [KW-1:0] k_out,
  output logic [PW-1:0] p_out,
  output logic          k_valid,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DWELL,
    S_STEP,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    M_SINGLE,
    M_REPEAT,
    M_TRIANGLE
  } sweep_e;

  state_e        state_q;
  sweep_e        mode_q;
  logic [KW-1:0] kstart_q;
  logic [KW-1:0] kstop_q;
  logic [KW-1:0] kstep_q;
  logic [DW-1:0] dwell_q;
  logic [PW-1:0] pcfg_q;
  logic [DW-1:0] cnt_q;
  logic          dir_dn_q;
  logic [KW-1:0] k_out_q;
  logic [PW-1:0] p_out_q;
  logic          k_valid_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic [KW:0]   sum_c;
  logic [KW-1:0] up_c;
  logic [KW-1:0] span_c;
  logic [KW-1:0] dn_c;
  logic [KW-1:0] k_next_c;
  logic          dir_dn_next_c;
  logic          end_single_c;
  logic [DW-1:0] dwell_m1_c;
  logic          cfg_bad_c;

  // Saturating up/down step candidates and end-of-leg handling for STEP.
  always_comb begin
    sum_c         = {1'b0, k_out_q} + {1'b0, kstep_q};
    up_c          = (sum_c > {1'b0, kstop_q}) ? kstop_q : sum_c[KW-1:0];
    span_c        = k_out_q - kstart_q;
    dn_c          = (span_c <= kstep_q) ? kstart_q : (k_out_q - kstep_q);
    k_next_c      = k_out_q;
    dir_dn_next_c = dir_dn_q;
    end_single_c  = 1'b0;
    if (!dir_dn_q) begin
      if (k_out_q == kstop_q) begin
        case (mode_q)
          M_REPEAT: k_next_c = kstart_q;
          M_TRIANGLE: begin
            k_next_c      = dn_c;
            dir_dn_next_c = 1'b1;
          end
          default: end_single_c = 1'b1;
        endcase
      end else begin
        k_next_c = up_c;
      end
    end else begin
      if (k_out_q == kstart_q) begin
        k_next_c      = up_c;
        dir_dn_next_c = 1'b0;
      end else begin
        k_next_c = dn_c;
      end
    end
  end

  // Dwell terminal count (a dwell of 0 behaves as 1) and config validity.
  always_comb begin
    dwell_m1_c = (dwell_q == '0) ? '0 : (dwell_q - DW'(1));
    cfg_bad_c  = (kstep_q == '0) || (kstart_q > kstop_q);
  end

  // Sweep state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= M_SINGLE;
      kstart_q  <= '0;
      kstop_q   <= '0;
      kstep_q   <= '0;
      dwell_q   <= '0;
      pcfg_q    <= '0;
      cnt_q     <= '0;
      dir_dn_q  <= 1'b0;
      k_out_q   <= '0;
      p_out_q   <= '0;
      k_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      k_valid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              case (mode)
                2'b01:   mode_q <= M_REPEAT;
                2'b10:   mode_q <= M_TRIANGLE;
                default: mode_q <= M_SINGLE;
              endcase
              kstart_q <= k_start;
              kstop_q  <= k_stop;
              kstep_q  <= k_step;
              dwell_q  <= dwell;
              pcfg_q   <= p_cfg;
              state_q  <= S_LOAD;
              busy_q   <= 1'b1;
            end
          end
          S_LOAD: begin
            if (cfg_bad_c) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              k_out_q   <= kstart_q;
              p_out_q   <= pcfg_q;
              k_valid_q <= 1'b1;
              dir_dn_q  <= 1'b0;
              cnt_q     <= '0;
              state_q   <= S_DWELL;
            end
          end
          S_DWELL: begin
            if (cnt_q == dwell_m1_c) begin
              cnt_q   <= '0;
              state_q <= S_STEP;
            end else begin
              cnt_q <= cnt_q + DW'(1);
            end
          end
          S_STEP: begin
            if (end_single_c) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              k_out_q   <= k_next_c;
              k_valid_q <= (k_next_c != k_out_q);
              dir_dn_q  <= dir_dn_next_c;
              cnt_q     <= '0;
              state_q   <= S_DWELL;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign k_out   = k_out_q;
  assign p_out   = p_out_q;
  assign k_valid = k_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS phase-accumulator core. It drives the core's frequency word K and phase-offset word P. On a start pulse it steps K linearly from a start word to a stop word, holding each value for a programmable dwell. It supports single-shot, repeating-sawtooth and triangle sweeps, with abort and error reporting. `k_out` and `p_out` connect directly to the K and P inputs of the DDS core.

## Interface
- `KW`, 32, width of frequency word K
- `PW`, 11, width of phase-offset word P
- `DW`, 16, width of dwell counter
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `start`  in  1  sweep request pulse; sampled only in IDLE
- `abort`  in  1  stop sweep; priority over every other input
- `mode`  in  2  00 single, 01 repeat (sawtooth), 10 triangle, 11 treated as 00
- `k_start`  in  KW  first frequency word
- `k_stop`  in  KW  last frequency word
- `k_step`  in  KW  increment per step
- `dwell`  in  DW  hold cycles per value; 0 treated as 1 (`dwell_eff`)
- `p_cfg`  in  PW  phase offset applied at sweep start
- `k_out`  out  KW  frequency word to DDS core, registered
- `p_out`  out  PW  phase word to DDS core, registered
- `k_valid`  out  1  one-cycle pulse in the first cycle a new `k_out` is visible
- `busy`  out  1  high in LOAD, DWELL, STEP
- `done`  out  1  one-cycle pulse on normal single-mode completion
- `err`  out  1  one-cycle pulse on rejected configuration

## Operation
- States: IDLE, LOAD, DWELL, STEP, DONE.
- **Reset:** state IDLE; `k_out`, `p_out`, `k_valid`, `busy`, `done`, `err` and internal direction/counters all 0.
- **IDLE**
  - `start`=1 and `abort`=0: latch `mode`, `k_start`, `k_stop`, `k_step`, `dwell`, `p_cfg` into shadow registers, then go to LOAD.
  - Inputs are not re-sampled until the next start.
- **LOAD**
  - Config error if `k_step`==0 or `k_start` > `k_stop` (unsigned): pulse `err`, return to IDLE, `k_out`/`p_out` unchanged.
  - Otherwise: `k_out`←`k_start`, `p_out`←`p_cfg`, direction←up, dwell counter←0, go to DWELL.
- **DWELL**
  - Counter increments each cycle.
  - At count == `dwell_eff`−1, go to STEP.
- **STEP, direction up**
  - If `k_out` == `k_stop`, this is end-of-leg.
  - Else `k_out` ← min(`k_out`+`k_step`, `k_stop`), go to DWELL.
  - The sum is computed in KW+1 bits, so it never wraps.
- **STEP, direction down (triangle only)**
  - If `k_out` == `k_start`, this is end-of-leg.
  - Else `k_out` ← max(`k_out`−`k_step`, `k_start`), computed without underflow, go to DWELL.
- **End-of-leg**
  - Single: go to DONE, `k_out` holds `k_stop`.
  - Repeat: `k_out`←`k_start`, go to DWELL.
  - Triangle: flip direction and apply one step in the new direction in the same STEP cycle, go to DWELL.
  - Degenerate triangle (`k_start`==`k_stop`): `k_out` stays constant, no `k_valid`; repeats until abort.
- **DONE:** `done`=1 for one cycle, then IDLE. `start` in DONE is ignored.
- **abort** in LOAD/DWELL/STEP/DONE: next state IDLE, `k_out`/`p_out` hold their current value, no `done`, no `err`.
  - `abort` in IDLE has no effect and suppresses a simultaneous `start`.
- `start` while busy is ignored, not queued.
- Repeat and triangle modes run until abort.

## Timing
- Cycle numbering: `start` high in cycle t (IDLE).
  - LOAD in t+1; `busy` high from t+1.
  - `k_out`=`k_start` with `k_valid` in t+2.
- Every `k_out` value, including the first and last, is held exactly `dwell_eff`+1 cycles (`dwell_eff` DWELL cycles plus 1 STEP cycle).
- `k_valid` pulses only when `k_out` actually changes value, or on the LOAD update.
  - It is not pulsed when a triangle turnaround or repeat reload leaves the value unchanged.
- Single mode: `done` is asserted `dwell_eff`+1 cycles after `k_out`=`k_stop` first appears; `busy` is low in the DONE cycle.
- Config error: `err` in t+2, `busy` low in t+2.
- Abort in cycle a: `busy` low in a+1.
- Reset mid-sweep returns to the reset values on the next edge regardless of state.

## Test plan
- **Single clamp-free:** `k_start`=100, `k_stop`=130, `k_step`=10, `dwell`=2 → `k_out` 100,110,120,130, each held 3 cycles, 4 `k_valid` pulses, `done` 3 cycles after 130 appears.
- **Clamp and overflow:**
  - 0/25/10 → 0,10,20,25, then done.
  - `k_start`=0xFFFFFFF0, `k_stop`=0xFFFFFFFF, `k_step`=0x20 → 0xFFFFFFF0, 0xFFFFFFFF, done; no wrap to a small value.
- **Triangle:** 0/20/10, `dwell`=0 → 0,10,20,10,0,10,20…, each held 2 cycles, no `done`; abort then → `busy` low next cycle, `k_out` frozen.
- **Repeat:** 5/15/5, `dwell`=1 → 5,10,15,5,10…; a `k_valid` pulse on each reload to 5.
- **Errors:**
  - `k_step`=0 → `err` pulse in t+2, `k_out` keeps its prior value, no `busy` after LOAD.
  - `k_start`=50, `k_stop`=40 → same response.
- **Races:**
  - `start`+`abort` in IDLE → nothing.
  - `start` during a sweep → ignored.
  - `rst` asserted during DWELL → all outputs 0 on the next edge, state IDLE.
